// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port synchronous memory between fetch and data ports.
// Define MEM_ARB_RR_EN to alternate grants on fetch/data conflicts instead of fixed data priority.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ireq,
   input  logic [31:0]       iaddr,
   output logic [31:0]       irdata,
   output logic              iready,
   input  logic              dreq,
   input  logic              dwe,
   input  logic [31:0]       daddr,
   input  logic [31:0]       dwdata,
   output logic [31:0]       drdata,
   output logic              dready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic {INSTR = 1'b0, DATA = 1'b1} gnt_t;

   localparam logic [3:0] LAT = 4'(RD_LAT);

   state_t              state_q, state_d;
   gnt_t                gnt_q, gnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [31:0]         irdata_q, irdata_d;
   logic [31:0]         drdata_q, drdata_d;
   logic                pick_data;

`ifdef MEM_ARB_RR_EN
   gnt_t                last_q, last_d;

   // On a conflict the requester that was not served last wins.
   assign pick_data = dreq && (!ireq || (last_q == INSTR));
`else
   assign pick_data = dreq;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         gnt_q    <= INSTR;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         irdata_q <= '0;
         drdata_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_q   <= INSTR;
`endif
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
`ifdef MEM_ARB_RR_EN
         last_q   <= last_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
`ifdef MEM_ARB_RR_EN
      last_d   = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (dreq || ireq) begin
               if (pick_data) begin
                  gnt_d   = DATA;
                  addr_d  = daddr[ADDR_W+1:2];
                  wdata_d = dwdata;
                  we_d    = dwe;
               end else begin
                  gnt_d   = INSTR;
                  addr_d  = iaddr[ADDR_W+1:2];
                  wdata_d = '0;
                  we_d    = 1'b0;
               end
`ifdef MEM_ARB_RR_EN
               last_d  = pick_data ? DATA : INSTR;
`endif
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = DONE;
            end else begin
               cnt_d   = LAT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            // Count reaches 1 in the RD_LAT-th cycle after ISSUE, when mem_rdata is valid.
            if (cnt_q == 4'd1) begin
               if (gnt_q == DATA) begin
                  drdata_d = mem_rdata;
               end else begin
                  irdata_d = mem_rdata;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_en    = (state_q == ISSUE);
   assign mem_we    = (state_q == ISSUE) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign iready    = (state_q == DONE) && (gnt_q == INSTR);
   assign dready    = (state_q == DONE) && (gnt_q == DATA);
   assign irdata    = irdata_q;
   assign drdata    = drdata_q;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{iaddr[1:0], iaddr[31:ADDR_W+2], daddr[1:0], daddr[31:ADDR_W+2]};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter at RD_LAT 2, 1 and 15.
module tb_mem_arbiter;

   localparam int AW = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq, dreq, dwe;
   logic [31:0] iaddr, daddr, dwdata, mem_rdata;

   logic [31:0]   irdata_w [3];
   logic [31:0]   drdata_w [3];
   logic [31:0]   mem_wdata_w [3];
   logic [AW-1:0] mem_addr_w [3];
   logic          iready_w [3];
   logic          dready_w [3];
   logic          mem_en_w [3];
   logic          mem_we_w [3];

   int sel = 0;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int both_hi = 0;

   logic [31:0]   s_irdata, s_drdata, s_mem_wdata;
   logic [AW-1:0] s_mem_addr;
   logic          s_iready, s_dready, s_mem_en, s_mem_we;

   typedef struct {int due; logic [31:0] d;} rd_t;
   rd_t         pend[$];
   logic [31:0] mem_arr [int];
   logic [31:0] ref_mem [int];

   mem_arbiter #(.ADDR_W(AW), .RD_LAT(2)) u_lat2 (
      .clk(clk), .reset(reset),
      .ireq(ireq), .iaddr(iaddr), .irdata(irdata_w[0]), .iready(iready_w[0]),
      .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata_w[0]), .dready(dready_w[0]),
      .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]),
      .mem_rdata(mem_rdata));

   mem_arbiter #(.ADDR_W(AW), .RD_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset),
      .ireq(ireq), .iaddr(iaddr), .irdata(irdata_w[1]), .iready(iready_w[1]),
      .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata_w[1]), .dready(dready_w[1]),
      .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]),
      .mem_rdata(mem_rdata));

   mem_arbiter #(.ADDR_W(AW), .RD_LAT(15)) u_lat15 (
      .clk(clk), .reset(reset),
      .ireq(ireq), .iaddr(iaddr), .irdata(irdata_w[2]), .iready(iready_w[2]),
      .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata_w[2]), .dready(dready_w[2]),
      .mem_en(mem_en_w[2]), .mem_we(mem_we_w[2]), .mem_addr(mem_addr_w[2]), .mem_wdata(mem_wdata_w[2]),
      .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      s_irdata    = irdata_w[sel];
      s_drdata    = drdata_w[sel];
      s_iready    = iready_w[sel];
      s_dready    = dready_w[sel];
      s_mem_en    = mem_en_w[sel];
      s_mem_we    = mem_we_w[sel];
      s_mem_addr  = mem_addr_w[sel];
      s_mem_wdata = mem_wdata_w[sel];
   end

   function automatic int lat_of(input int s);
      case (s)
         0: return 2;
         1: return 1;
         default: return 15;
      endcase
   endfunction

   function automatic logic [31:0] init_word(input int w);
      return (32'(w) * 32'h0001_0203) ^ 32'h5A00_0000;
   endfunction

   // Memory macro: valid data only in the RD_LAT-th cycle after the strobe, garbage otherwise.
   always @(negedge clk) begin
      logic [31:0] v;
      rd_t keep[$];
      rd_t r;
      int k;
      v = $urandom;
      keep = {};
      foreach (pend[i]) begin
         if (pend[i].due == cyc) v = pend[i].d;
         if (pend[i].due > cyc) keep.push_back(pend[i]);
      end
      pend = keep;
      if (s_mem_en) begin
         k = int'(s_mem_addr);
         if (s_mem_we) begin
            mem_arr[k] = s_mem_wdata;
         end else begin
            r.due = cyc + lat_of(sel);
            r.d   = mem_arr.exists(k) ? mem_arr[k] : init_word(k);
            pend.push_back(r);
         end
      end
      mem_rdata = v;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (iready_w[i] && dready_w[i]) both_hi++;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
      iaddr = '0; daddr = '0; dwdata = '0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic xact(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, output int en_cyc);
      int t0, lat, rdy_cyc, n_en, k, exp_rdy;
      logic [31:0] exp_rd, own_before, other_before, got_rd, other_after;
      logic [AW-1:0] got_addr;
      logic got_we;
      logic [31:0] got_wd;
      bit port_ok;
      lat = lat_of(sel);
      k = int'(addr[AW+1:2]);
      exp_rd = '0;
      if (we) ref_mem[k] = wd;
      else exp_rd = ref_mem.exists(k) ? ref_mem[k] : init_word(k);
      own_before   = is_d ? s_drdata : s_irdata;
      other_before = is_d ? s_irdata : s_drdata;
      t0 = cyc; en_cyc = -1; rdy_cyc = -1; n_en = 0;
      got_addr = '0; got_we = 1'b0; got_wd = '0; got_rd = '0; port_ok = 1'b0;
      if (is_d) begin
         dreq = 1'b1; dwe = we; daddr = addr; dwdata = wd;
      end else begin
         ireq = 1'b1; iaddr = addr;
      end
      for (int n = 0; n < lat + 8 && rdy_cyc < 0; n++) begin
         @(negedge clk);
         if (s_mem_en) begin
            n_en++;
            if (en_cyc < 0) begin
               en_cyc = cyc; got_addr = s_mem_addr; got_we = s_mem_we; got_wd = s_mem_wdata;
            end
         end
         if (s_iready || s_dready) begin
            rdy_cyc = cyc;
            port_ok = is_d ? (s_dready && !s_iready) : (s_iready && !s_dready);
            got_rd  = is_d ? s_drdata : s_irdata;
         end
      end
      other_after = is_d ? s_irdata : s_drdata;
      @(posedge clk);
      #1;
      if (is_d) dreq = 1'b0; else ireq = 1'b0;
      exp_rdy = we ? t0 + 2 : t0 + lat + 2;
      checks++;
      if (rdy_cyc !== exp_rdy) begin
         errors++; $display("FAIL ready_cycle lat=%0d got %0d expected %0d", lat, rdy_cyc - t0, exp_rdy - t0);
      end
      checks++;
      if (!port_ok) begin
         errors++; $display("FAIL ready_port is_d=%0d got %0d expected 1", is_d, port_ok);
      end
      checks++;
      if (n_en !== 1 || en_cyc !== t0 + 1) begin
         errors++; $display("FAIL mem_en_timing got count %0d at +%0d expected 1 at +1", n_en, en_cyc - t0);
      end
      checks++;
      if (got_addr !== addr[AW+1:2] || got_we !== we) begin
         errors++; $display("FAIL mem_addr_we got %h/%0d expected %h/%0d", got_addr, got_we, addr[AW+1:2], we);
      end
      if (we) begin
         checks++;
         if (got_wd !== wd) begin
            errors++; $display("FAIL mem_wdata got %h expected %h", got_wd, wd);
         end
         checks++;
         if (got_rd !== own_before) begin
            errors++; $display("FAIL drdata_after_write got %h expected %h", got_rd, own_before);
         end
      end else begin
         checks++;
         if (got_rd !== exp_rd) begin
            errors++; $display("FAIL read_data is_d=%0d addr=%h got %h expected %h", is_d, addr, got_rd, exp_rd);
         end
      end
      checks++;
      if (other_after !== other_before) begin
         errors++; $display("FAIL other_rdata_hold got %h expected %h", other_after, other_before);
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({iready_w[i], dready_w[i], mem_en_w[i], mem_we_w[i]} !== 4'b0000 ||
             mem_addr_w[i] !== '0 || mem_wdata_w[i] !== '0 ||
             irdata_w[i] !== '0 || drdata_w[i] !== '0) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d got %b/%h/%h/%h/%h expected 0",
                     i, {iready_w[i], dready_w[i], mem_en_w[i], mem_we_w[i]},
                     mem_addr_w[i], mem_wdata_w[i], irdata_w[i], drdata_w[i]);
         end
      end
   endtask

   task automatic test_fetch_and_write();
      int e;
      sel = 0;
      do_reset();
      mem_arr[2] = 32'hE3A01005;
      ref_mem[2] = 32'hE3A01005;
      xact(1'b0, 1'b0, 32'h0000_0008, 32'h0, e);
      xact(1'b1, 1'b1, 32'h0000_0064, 32'hDEAD_BEEF, e);
      xact(1'b1, 1'b0, 32'h0000_0064, 32'h0, e);
      xact(1'b0, 1'b0, 32'h0000_0064, 32'h0, e);
   endtask

   task automatic test_conflict();
      bit gr[$];
      bit exp_g;
      int lat, budget;
      logic [31:0] got, expv;
      sel = 0;
      lat = lat_of(sel);
      do_reset();
      ireq = 1'b1; iaddr = 32'h0000_0020;
      dreq = 1'b1; dwe = 1'b0; daddr = 32'h0000_0040;
      budget = 4 * (lat + 4) + 10;
      while (gr.size() < 4 && budget > 0) begin
         @(negedge clk);
         budget--;
         if (s_iready || s_dready) begin
            gr.push_back(s_dready);
            got  = s_dready ? s_drdata : s_irdata;
            expv = s_dready ? (ref_mem.exists(16) ? ref_mem[16] : init_word(16))
                            : (ref_mem.exists(8) ? ref_mem[8] : init_word(8));
            checks++;
            if (got !== expv) begin
               errors++; $display("FAIL conflict_data grant=%0d got %h expected %h", s_dready, got, expv);
            end
         end
      end
      @(posedge clk);
      #1 ireq = 1'b0; dreq = 1'b0;
      checks++;
      if (gr.size() !== 4) begin
         errors++; $display("FAIL conflict_grants got %0d expected 4", gr.size());
      end
      foreach (gr[i]) begin
`ifdef MEM_ARB_RR_EN
         exp_g = (i % 2 == 0);
`else
         exp_g = 1'b1;
`endif
         checks++;
         if (gr[i] !== exp_g) begin
            errors++; $display("FAIL conflict_order idx=%0d got %0d expected %0d", i, gr[i], exp_g);
         end
      end
   endtask

   task automatic test_reset_in_wait();
      int pulses, e;
      sel = 0;
      do_reset();
      ireq = 1'b1; iaddr = 32'h0000_0010;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1; ireq = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_mem_en, s_mem_we, s_iready, s_dready} !== 4'b0000 || s_mem_addr !== '0 || s_irdata !== '0) begin
         errors++;
         $display("FAIL reset_wait_outputs got %b/%h/%h expected 0",
                  {s_mem_en, s_mem_we, s_iready, s_dready}, s_mem_addr, s_irdata);
      end
      pulses = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (s_iready || s_dready || s_mem_en) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++; $display("FAIL reset_wait_no_ready got %0d expected 0", pulses);
      end
      @(posedge clk);
      #1;
      xact(1'b0, 1'b0, 32'h0000_0014, 32'h0, e);
   endtask

   task automatic test_back_to_back();
      int e1, e2;
      sel = 0;
      do_reset();
      xact(1'b0, 1'b0, 32'h0000_0000, 32'h0, e1);
      xact(1'b0, 1'b0, 32'h0000_0004, 32'h0, e2);
      checks++;
      if (e2 - e1 !== lat_of(sel) + 3) begin
         errors++; $display("FAIL back_to_back_gap got %0d expected %0d", e2 - e1, lat_of(sel) + 3);
      end
   endtask

   task automatic test_boundary_latency();
      int e;
      for (int s = 1; s < 3; s++) begin
         sel = s;
         do_reset();
         xact(1'b0, 1'b0, 32'h0000_0030, 32'h0, e);
         xact(1'b1, 1'b1, 32'h0000_0034, 32'h1234_5678 + 32'(s), e);
         xact(1'b1, 1'b0, 32'h0000_0034, 32'h0, e);
      end
   endtask

   task automatic test_random();
      int e;
      bit is_d, we;
      logic [31:0] addr, r;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         do_reset();
         for (int n = 0; n < 10; n++) begin
            is_d = 1'($urandom_range(0, 1));
            we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            r    = $urandom;
            addr = (r & 32'hFFFC_0000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            xact(is_d, we, addr, $urandom, e);
         end
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (both_hi !== 0) begin
         errors++; $display("FAIL ready_exclusive got %0d cycles expected 0", both_hi);
      end
   endtask

   initial begin
      reset = 1'b1;
      ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
      iaddr = '0; daddr = '0; dwdata = '0;
      test_reset();
      test_fetch_and_write();
      test_conflict();
      test_reset_in_wait();
      test_back_to_back();
      test_boundary_latency();
      test_random();
      test_exclusive();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
